// File: rtl/etroc_stream_pkg.sv
// Shared types for the ETROC output stream: grant source codes, arbiter FSM states and
// the default no-data filler word.
package etroc_stream_pkg;

   typedef enum logic [2:0] {
      DtCh0    = 3'd0,
      DtCh1    = 3'd1,
      DtCh2    = 3'd2,
      DtCh3    = 3'd3,
      DtTs     = 3'd4,
      DtNoData = 3'd5,
      DtMiss   = 3'd6,
      DtNone   = 3'd7
   } data_type_e;

   typedef enum logic [1:0] {
      StNormal       = 2'd0,
      StMissBurst    = 2'd1,
      StBackpressure = 2'd2
   } state_e;

   localparam logic [31:0] NodataWordDefault = 32'hFFFF_FFFC;

   function automatic logic [31:0] ch_word(input logic [127:0] data, input logic [1:0] idx);
      return data[{idx, 5'd0} +: 32];
   endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin selector: grants the first requester found at or after ptr_i.
module rr_arb4 (
   input  logic [3:0] req_i,
   input  logic [1:0] ptr_i,
   output logic [3:0] gnt_o,
   output logic [1:0] idx_o
);

   logic [1:0] cand;
   logic       found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_i + 2'(i);
         if (!found && req_i[cand]) begin
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/out_fifo_arbiter.sv
// Arbitrates missed-event, timestamp and four TDC channel words into one output FIFO,
// discarding words under almost-full and inserting a filler word after an idle stretch.
module out_fifo_arbiter
   import etroc_stream_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT = 16,
   parameter logic [31:0] NODATA_WORD  = NodataWordDefault
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] ch_data,
   input  logic [3:0]   ch_valid,
   output logic [3:0]   ch_ready,
   input  logic [31:0]  ts_data,
   input  logic         ts_valid,
   output logic         ts_ready,
   input  logic [31:0]  miss_data,
   input  logic         miss_req,
   output logic         miss_ack,
   input  logic         fifo_almostfull,
   output logic         fifo_wr_en,
   output logic [31:0]  fifo_din,
   output logic [2:0]   dataType,
   output logic [15:0]  drop_count
);

   localparam logic [7:0] IdleLast = 8'(IDLE_TIMEOUT - 1);

   state_e     state_q, state_d;
   data_type_e grant;
   logic       run_q;
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0] idle_q, idle_d;
   logic [15:0] drop_q, drop_d;
   logic       wr_en_q, wr_en_d;
   logic [31:0] din_q, din_d;
   logic [3:0] rr_gnt;
   logic [1:0] rr_idx;
   logic       sel_ch, normal_wr, discard;

   rr_arb4 u_rr_arb4 (
      .req_i (ch_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (rr_gnt),
      .idx_o (rr_idx)
   );

   // run_q holds every output at its reset value until the first edge after release.
   always_comb begin
      state_d   = state_q;
      grant     = DtNone;
      sel_ch    = 1'b0;
      normal_wr = (state_q == StNormal) && !fifo_almostfull;
      discard   = (state_q == StBackpressure) || ((state_q == StNormal) && fifo_almostfull);
      if (run_q) begin
         unique case (state_q)
            StNormal: begin
               if (fifo_almostfull) state_d = StBackpressure;
               else if (miss_req)   state_d = StMissBurst;
            end
            StMissBurst: begin
               if (fifo_almostfull) state_d = StBackpressure;
               else if (!miss_req)  state_d = StNormal;
            end
            StBackpressure: begin
               if (!fifo_almostfull) state_d = StNormal;
            end
            default: state_d = StNormal;
         endcase
         if (state_q == StMissBurst) begin
            if (miss_req && !fifo_almostfull) grant = DtMiss;
         end else if (normal_wr && miss_req) begin
            grant = DtMiss;
         end else if (ts_valid) begin
            grant = DtTs;
         end else if (|ch_valid) begin
            grant  = data_type_e'({1'b0, rr_idx});
            sel_ch = 1'b1;
         end else if (normal_wr && (idle_q == IdleLast)) begin
            grant = DtNoData;
         end
      end
   end

   always_comb begin
      ch_ready = sel_ch ? rr_gnt : 4'b0000;
      ts_ready = (grant == DtTs);
      miss_ack = (grant == DtMiss);
      dataType = grant;

      wr_en_d = (grant != DtNone) && !discard;
      din_d   = din_q;
      if (wr_en_d) begin
         unique case (grant)
            DtTs:     din_d = ts_data;
            DtNoData: din_d = NODATA_WORD;
            DtMiss:   din_d = miss_data;
            default:  din_d = ch_word(ch_data, rr_idx);
         endcase
      end

      drop_d = drop_q;
      if ((grant != DtNone) && discard && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

      rr_ptr_d = sel_ch ? rr_idx + 2'd1 : rr_ptr_q;

      idle_d = idle_q;
      if (run_q) begin
         idle_d = ((state_q == StNormal) && (state_d == StNormal) && (grant == DtNone)) ?
                  idle_q + 8'd1 : 8'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StNormal;
         run_q    <= 1'b0;
         rr_ptr_q <= '0;
         idle_q   <= '0;
         drop_q   <= '0;
         wr_en_q  <= 1'b0;
         din_q    <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= 1'b1;
         rr_ptr_q <= rr_ptr_d;
         idle_q   <= idle_d;
         drop_q   <= drop_d;
         wr_en_q  <= wr_en_d;
         din_q    <= din_d;
      end
   end

   assign fifo_wr_en = wr_en_q;
   assign fifo_din   = din_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_out_fifo_arbiter.sv
// Randomised and directed bench for out_fifo_arbiter against a queue-free behavioural model.
module tb_out_fifo_arbiter;

   localparam int          IdleTimeout = 16;
   localparam logic [31:0] NoData      = 32'hFFFF_FFFC;
   localparam int          MN = 0, MB = 1, MP = 2;  // normal, miss burst, backpressure

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] ch_data;
   logic [3:0]   ch_valid, ch_ready;
   logic [31:0]  ts_data, miss_data, fifo_din;
   logic         ts_valid, ts_ready, miss_req, miss_ack, fifo_almostfull, fifo_wr_en;
   logic [2:0]   dataType;
   logic [15:0]  drop_count;

   out_fifo_arbiter #(
      .IDLE_TIMEOUT (IdleTimeout),
      .NODATA_WORD  (NoData)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ch_data         (ch_data),
      .ch_valid        (ch_valid),
      .ch_ready        (ch_ready),
      .ts_data         (ts_data),
      .ts_valid        (ts_valid),
      .ts_ready        (ts_ready),
      .miss_data       (miss_data),
      .miss_req        (miss_req),
      .miss_ack        (miss_ack),
      .fifo_almostfull (fifo_almostfull),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_din        (fifo_din),
      .dataType        (dataType),
      .drop_count      (drop_count)
   );

   always #3 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model state: mode, next channel to search from, idle run length, drops, pending write
   int          m_mode, m_next_ch, m_idle, m_drops;
   bit          m_run, m_wr;
   logic [31:0] m_din;

   logic [2:0]  s_dt;
   logic [3:0]  s_rdy;
   logic        s_ack, s_wr;
   logic [31:0] s_din;
   logic [15:0] s_drop;

   int miss_left, af_left, nd_count, nd_at;
   bit hit;
   logic [2:0] rr_seq [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = MN; m_next_ch = 0; m_idle = 0; m_drops = 0;
      m_run = 0; m_wr = 0; m_din = '0;
   endtask

   function automatic int model_grant();
      int c;
      if (!m_run) return 7;
      if (m_mode == MB) return (miss_req && !fifo_almostfull) ? 6 : 7;
      if (m_mode == MN && !fifo_almostfull && miss_req) return 6;
      if (ts_valid) return 4;
      for (int i = 0; i < 4; i++) begin
         c = (m_next_ch + i) % 4;
         if (ch_valid[c]) return c;
      end
      if (m_mode == MN && !fifo_almostfull && m_idle == IdleTimeout - 1) return 5;
      return 7;
   endfunction

   function automatic logic [31:0] model_word(input int g);
      case (g)
         4:       return ts_data;
         5:       return NoData;
         6:       return miss_data;
         default: return ch_data[32*g +: 32];
      endcase
   endfunction

   task automatic model_step();
      int g, nm;
      bit disc;
      if (!reset) begin
         model_reset();
         return;
      end
      g    = model_grant();
      disc = (m_mode == MP) || (m_mode == MN && fifo_almostfull);
      m_wr = (g != 7) && !disc;
      if (m_wr) m_din = model_word(g);
      if (g != 7 && disc && m_drops < 65535) m_drops++;
      if (g < 4) m_next_ch = (g + 1) % 4;
      nm = m_mode;
      if (m_run) begin
         if (m_mode == MN) begin
            if (fifo_almostfull) nm = MP;
            else if (miss_req) nm = MB;
         end else if (m_mode == MB) begin
            if (fifo_almostfull) nm = MP;
            else if (!miss_req) nm = MN;
         end else if (!fifo_almostfull) begin
            nm = MN;
         end
         m_idle = (m_mode == MN && nm == MN && g == 7) ? m_idle + 1 : 0;
      end
      m_mode = nm;
      m_run  = 1;
   endtask

   task automatic compare_all();
      int g;
      g = model_grant();
      chk("dataType", 32'(dataType), 32'(g));
      chk("ch_ready", 32'(ch_ready), (g < 4) ? (32'd1 << g) : 32'd0);
      chk("ts_ready", 32'(ts_ready), 32'(g == 4));
      chk("miss_ack", 32'(miss_ack), 32'(g == 6));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr));
      chk("fifo_din", fifo_din, m_din);
      chk("drop_count", 32'(drop_count), 32'(m_drops));
   endtask

   always @(negedge clk) compare_all();

   task automatic cycle();
      @(negedge clk);
      s_dt = dataType; s_rdy = ch_ready; s_ack = miss_ack;
      s_wr = fifo_wr_en; s_din = fifo_din; s_drop = drop_count;
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      reset = 1'b0; ch_data = '0; ch_valid = '0; ts_data = '0; ts_valid = 1'b0;
      miss_data = '0; miss_req = 1'b0; fifo_almostfull = 1'b0;
      model_reset();
      repeat (3) cycle();

      // reset held with all channels requesting, then released between edges
      ch_valid = 4'hF;
      ch_data  = {32'hC300_0003, 32'hC200_0002, 32'hC100_0001, 32'hC000_0000};
      cycle();
      chk("rst_dt", 32'(s_dt), 32'd7);
      chk("rst_ready", 32'(s_rdy), 32'd0);
      chk("rst_wr", 32'(s_wr), 32'd0);
      reset = 1'b1;
      cycle();
      chk("rel_dt", 32'(s_dt), 32'd7);
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (i < 5) rr_seq[i] = s_dt;
         if (i > 0) chk("rr_wr", 32'(s_wr), 32'd1);
         if (i == 1) chk("rr_din0", s_din, 32'hC000_0000);
      end
      chk("rr_0", 32'(rr_seq[0]), 32'd0);
      chk("rr_1", 32'(rr_seq[1]), 32'd1);
      chk("rr_2", 32'(rr_seq[2]), 32'd2);
      chk("rr_3", 32'(rr_seq[3]), 32'd3);
      chk("rr_4", 32'(rr_seq[4]), 32'd0);

      // miss burst beats timestamp and channel
      ch_valid = 4'b0001; ts_valid = 1'b1; ts_data = 32'h7500_0001; miss_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         miss_data = 32'hB000_0000 + 32'(k);
         cycle();
         chk("miss_dt", 32'(s_dt), 32'd6);
         chk("miss_ack", 32'(s_ack), 32'd1);
         if (k > 0) chk("miss_din", s_din, 32'hB000_0000 + 32'(k - 1));
      end
      miss_req = 1'b0;
      cycle();
      chk("miss_din_last", s_din, 32'hB000_0002);
      chk("burst_exit_dt", 32'(s_dt), 32'd7);
      cycle();
      chk("ts_after_miss", 32'(s_dt), 32'd4);

      // ten almost-full cycles on channel 2
      ts_valid = 1'b0; ch_valid = 4'b0100; fifo_almostfull = 1'b1;
      for (int i = 0; i < 10; i++) begin
         miss_req = (i >= 5);
         cycle();
         chk("bp_dt", 32'(s_dt), 32'd2);
         chk("bp_ack", 32'(s_ack), 32'd0);
         if (i > 0) chk("bp_wr", 32'(s_wr), 32'd0);
      end
      fifo_almostfull = 1'b0; ch_valid = 4'b0000; miss_req = 1'b0;
      cycle();
      chk("bp_drops", 32'(s_drop), 32'd10);
      chk("bp_exit_wr", 32'(s_wr), 32'd0);

      // miss request arriving as almost-full falls
      fifo_almostfull = 1'b1;
      repeat (2) cycle();
      fifo_almostfull = 1'b0; miss_req = 1'b1; miss_data = 32'hD00D_0001;
      cycle();
      chk("af_fall_dt", 32'(s_dt), 32'd7);
      cycle();
      chk("af_fall_next", 32'(s_dt), 32'd6);
      cycle();
      chk("af_fall_burst", 32'(s_dt), 32'd6);
      miss_req = 1'b0;
      cycle();

      // idle filler after the timeout
      ts_valid = 1'b1;
      cycle();
      ts_valid = 1'b0; nd_count = 0; nd_at = -1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (s_dt == 3'd5) begin nd_count++; nd_at = i; end
         if (i == 16) begin
            chk("nodata_wr", 32'(s_wr), 32'd1);
            chk("nodata_din", s_din, NoData);
         end
      end
      chk("nodata_count", 32'(nd_count), 32'd1);
      chk("nodata_cycle", 32'(nd_at), 32'd15);

      // reset pulse in the middle of a burst
      miss_req = 1'b1; miss_data = 32'hE000_0001;
      repeat (2) cycle();
      reset = 1'b0;
      model_reset();
      #1;
      reset = 1'b1;
      cycle();
      chk("rstb_dt", 32'(s_dt), 32'd7);
      chk("rstb_wr", 32'(s_wr), 32'd0);
      chk("rstb_drop", 32'(s_drop), 32'd0);
      chk("rstb_ack", 32'(s_ack), 32'd0);
      miss_req = 1'b0;
      cycle();

      // random traffic with periodic quiet windows
      miss_left = 0; af_left = 0;
      for (int i = 0; i < 1500; i++) begin
         if ((i % 300) >= 280) begin
            ch_valid = '0; ts_valid = 1'b0; miss_req = 1'b0; fifo_almostfull = 1'b0;
            miss_left = 0; af_left = 0;
         end else begin
            ch_valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ch_valid = '0;
            ts_valid = ($urandom_range(0, 4) == 0);
            if (miss_left == 0 && $urandom_range(0, 19) == 0) miss_left = $urandom_range(1, 5);
            miss_req = (miss_left != 0);
            if (miss_left != 0) miss_left--;
            if (af_left == 0 && $urandom_range(0, 24) == 0) af_left = $urandom_range(1, 12);
            fifo_almostfull = (af_left != 0);
            if (af_left != 0) af_left--;
         end
         ch_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
         ts_data   = $urandom();
         miss_data = $urandom();
         cycle();
      end

      // drive drop_count to saturation
      miss_req = 1'b0; ts_valid = 1'b0; ch_valid = 4'b1000; fifo_almostfull = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 70000 && !hit; i++) begin
         cycle();
         if (s_drop == 16'hFFFE) hit = 1'b1;
      end
      chk("sat_reach", 32'(hit), 32'd1);
      repeat (3) cycle();
      chk("sat_value", 32'(s_drop), 32'h0000_FFFF);
      fifo_almostfull = 1'b0; ch_valid = '0;
      repeat (2) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
